imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 33 +++
 rtl/imem_loader_word_packer.sv | 58 +++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  // Header is a 16-bit big-endian word count
  localparam int HDR_W          = 16;
  // Instruction words are assembled from four stream bytes
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // States in which the loader is willing to take stream bytes
  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
// ============================================================================
// Module      : word_packer
// Description : Shifts stream bytes MSB-first into an instruction word and
//               flags the byte that completes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  // Only the leading bytes need storage; the final byte goes straight out.
  logic [WORD_W-9:0]     shift_q;
  logic [WORD_W-9:0]     shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [BYTE_CNT_W-1:0] cnt_d;

  // Next-state for the partial word and byte position
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      shift_d = {shift_q[WORD_W-17:0], byte_i};
      cnt_d   = (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
    end
  end

  // Partial word and byte position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o = {shift_q, byte_i};
  assign done_o = valid_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Parses a byte stream (16-bit word count + big-endian words)
//               and writes it into instruction memory, holding the core in
//               reset until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] DEPTH = 32'(2 ** ADDR_W);

  state_e              state_q;
  state_e              state_d;
  logic                in_ready_q;
  logic                done_q;
  logic                error_q;
  logic                cpu_reset_q;
  logic [7:0]          hdr_hi_q;
  logic [ADDR_W-1:0]   last_idx_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic                drain_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;

  logic                xfer;
  logic [HDR_W-1:0]    hdr_n;
  logic [HDR_W-1:0]    hdr_n_m1;
  logic                pack_valid;
  logic                pack_clear;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_done;
  logic                last_word;

  assign xfer      = in_valid && in_ready_q;
  assign hdr_n     = {hdr_hi_q, in_data};
  assign hdr_n_m1  = hdr_n - 16'd1;
  assign last_word = (word_idx_q == last_idx_q);

  // Bytes arriving while the final word is being written are dropped so
  // nothing beyond word N-1 can ever reach memory.
  assign pack_valid = xfer && (state_q == DATA) && !drain_q;
  assign pack_clear = (state_q != DATA);

  word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (pack_clear),
    .valid_i (pack_valid),
    .byte_i  (in_data),
    .word_o  (pack_word),
    .done_o  (pack_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DATA lingers one cycle after the last word so that
  // done follows the final write strobe instead of coinciding with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR_HI: begin
        if (xfer) state_d = HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if (hdr_n == '0)               state_d = DONE;
          else if (32'(hdr_n) > DEPTH)   state_d = ERR;
          else                           state_d = DATA;
        end
      end
      DATA: begin
        if (drain_q) state_d = DONE;
      end
      DONE, ERR: begin
        if (reload) state_d = HDR_HI;
      end
      default: state_d = HDR_HI;
    endcase
  end

  // Header capture, word indexing and end-of-image detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_hi_q   <= '0;
      last_idx_q <= '0;
      word_idx_q <= '0;
      drain_q    <= 1'b0;
    end else begin
      if (xfer && (state_q == HDR_HI)) begin
        hdr_hi_q <= in_data;
      end
      if (xfer && (state_q == HDR_LO)) begin
        last_idx_q <= ADDR_W'(hdr_n_m1);
        word_idx_q <= '0;
      end else if (pack_done) begin
        word_idx_q <= word_idx_q + 1'b1;
      end
      drain_q <= pack_done && last_word;
    end
  end

  // Memory write port: one strobe the cycle after each completed word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= pack_done;
      if (pack_done) begin
        mem_addr_q  <= word_idx_q;
        mem_wdata_q <= pack_word;
      end
    end
  end

  // Status outputs registered from next state so they track the state
  // register exactly and are glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      in_ready_q  <= accepts_bytes(state_d);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
      cpu_reset_q <= (state_d != DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: table vectors, corner
//               sequences and randomized streams against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int vecs   = 0;
  int miscmp = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/strobe monitor
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];
  int   done_rise = -1;
  int   cpr_fall  = -1;
  int   overlap   = 0;
  logic done_prev = 1'b0;
  logic cpr_prev  = 1'b1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    if (cpu_reset === 1'b0 && cpr_prev !== 1'b0) cpr_fall = cyc;
    if (mem_we === 1'b1 && done === 1'b1) overlap++;
    done_prev = done;
    cpr_prev  = cpu_reset;
  end

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gappy;
    bit          exp_done;
    bit          exp_err;
    int          exp_nwr;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] stim[$];
  logic [31:0] expw[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return w0 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Reference model: which words end up in memory for a given count
  task automatic model(input int n);
    expw.delete();
    if (n >= 1 && n <= DEPTH)
      for (int i = 0; i < n; i++) expw.push_back(stim[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic stop_stream(input bit junk);
    if (junk) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int base);
    int nact = wa_q.size() - base;
    chk({tag, "_nwrites"}, 32'(nact), 32'(expw.size()));
    for (int i = 0; i < nact && i < expw.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa_q[base+i]), 32'(i));
      chk({tag, "_data"}, wd_q[base+i], expw[i]);
    end
  endtask

  task automatic run_case(input string tag, input logic [15:0] n, input bit gappy,
                          input bit junk, input bit exp_done, input bit exp_err);
    int base = wa_q.size();
    int ovl0 = overlap;
    send_byte(n[15:8], gappy);
    send_byte(n[7:0], gappy);
    if (!exp_err)
      for (int i = 0; i < int'(n); i++)
        for (int k = 3; k >= 0; k--) send_byte(stim[i][8*k +: 8], gappy);
    stop_stream(junk);
    wait_end();
    chk({tag, "_done"},      {31'd0, done},      {31'd0, exp_done});
    chk({tag, "_error"},     {31'd0, error},     {31'd0, exp_err});
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check_writes(tag, base);
    chk({tag, "_overlap"}, 32'(overlap - ovl0), 32'd0);
    if (expw.size() > 0 && wa_q.size() - base == expw.size()) begin
      chk({tag, "_done_lag"}, 32'(done_rise), 32'(wc_q[wa_q.size()-1] + 1));
      chk({tag, "_cpr_fall"}, 32'(cpr_fall), 32'(done_rise));
    end
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_rl_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_rl_done"},      {31'd0, done},      32'd0);
    chk({tag, "_rl_error"},     {31'd0, error},     32'd0);
    chk({tag, "_rl_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] n;
    bit junk;

    tbl[0] = '{16'd2,   32'h2008_0005, 32'hAC08_0040, 1'b0, 1'b1, 1'b0, 2};
    tbl[1] = '{16'd0,   32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{16'h41,  32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{16'd1,   32'h1234_5678, 32'h0,         1'b1, 1'b1, 1'b0, 1};
    tbl[4] = '{16'd1,   32'hCAFE_BABE, 32'h0,         1'b0, 1'b1, 1'b0, 1};
    tbl[5] = '{16'd64,  32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 64};
    tbl[6] = '{16'd65,  32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 0};
    tbl[7] = '{16'h100, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_error",     {31'd0, error},     32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),      32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);

    reset = 1'b0;
    #1;
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_in_ready_first_edge",  {31'd0, in_ready}, 32'd1);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      stim.delete();
      for (int i = 0; i < int'(tbl[v].n) && i <= DEPTH; i++)
        stim.push_back(word_of(i, tbl[v].w0, tbl[v].w1));
      model(int'(tbl[v].n));
      chk($sformatf("tbl%0d_model_nwr", v), 32'(expw.size()), 32'(tbl[v].exp_nwr));
      run_case($sformatf("tbl%0d", v), tbl[v].n, tbl[v].gappy, 1'b0,
               tbl[v].exp_done, tbl[v].exp_err);
      do_reload($sformatf("tbl%0d", v));
    end

    // Reset mid-word discards partial data and clears the write port
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stop_stream(1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_mem_addr",  32'(mem_addr),      32'd0);
    chk("midrst_mem_wdata", mem_wdata,          32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full stream after reset, with a reload pulse in HDR_LO that must be ignored
    base = wa_q.size();
    send_byte(8'h00, 1'b0);
    stop_stream(1'b0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    chk("ign_reload_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ign_reload_done",     {31'd0, done},     32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    stop_stream(1'b0);
    wait_end();
    stim.delete();
    stim.push_back(32'hDEAD_BEEF);
    model(1);
    check_writes("midrst", base);
    chk("midrst_done", {31'd0, done}, 32'd1);
    do_reload("midrst");

    // Randomized streams against the model
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) n = 16'($urandom_range(DEPTH + 1, 300));
      else                           n = 16'($urandom_range(0, 12));
      junk = 1'($urandom);
      stim.delete();
      for (int i = 0; i < int'(n) && i <= DEPTH; i++) stim.push_back($urandom);
      model(int'(n));
      run_case($sformatf("rnd%0d", r), n, 1'($urandom), junk,
               int'(n) <= DEPTH, int'(n) > DEPTH);
      do_reload($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

`default_nettype wire
